// File: rtl/ssp_rx.sv
// ssp_rx: TI-style SSP receiver; synchronised serial input, MSB-first deserialiser, FWFT receive FIFO.
// Define SSP_RX_OVERRUN_EN to add the sticky rx_overrun flag and its ovr_clr input.
module ssp_rx #(
   parameter int DEPTH = 4,
   parameter int DW = 8
) (
   input  logic PCLK,
   input  logic CLEAR_B,
   input  logic SSPCLKIN,
   input  logic SSPFSSIN,
   input  logic SSPRXD,
   input  logic rd_en,
   output logic [DW-1:0] RxData,
   output logic rx_empty,
   output logic SSPRXINTR,
`ifdef SSP_RX_OVERRUN_EN
   output logic rx_overrun,
   input  logic ovr_clr,
`endif
   output logic [$clog2(DEPTH):0] rx_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(DW);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state;
   logic [1:0] clk_s, fss_s, rxd_s;
   logic clk_q, sample_en, fss, rxd;
   logic [DW-2:0] shreg;
   logic [BW-1:0] bitcnt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [AW:0] cnt_next;
   logic push, pop, wr;
   logic [DW-1:0] din;

   // fss and rxd get the same total delay as the edge detector so each sample lines up with its edge
   always_ff @(posedge PCLK or negedge CLEAR_B)
      if (!CLEAR_B) begin
         clk_s <= '0;
         fss_s <= '0;
         rxd_s <= '0;
         clk_q <= 1'b0;
         sample_en <= 1'b0;
         fss <= 1'b0;
         rxd <= 1'b0;
      end else begin
         clk_s <= {clk_s[0], SSPCLKIN};
         fss_s <= {fss_s[0], SSPFSSIN};
         rxd_s <= {rxd_s[0], SSPRXD};
         clk_q <= clk_s[1];
         sample_en <= clk_q & ~clk_s[1];
         fss <= fss_s[1];
         rxd <= rxd_s[1];
      end

   assign din = {shreg, rxd};
   assign push = sample_en && state == SHIFT && bitcnt == BW'(DW-1);

   always_ff @(posedge PCLK or negedge CLEAR_B)
      if (!CLEAR_B) begin
         state <= IDLE;
         bitcnt <= '0;
         shreg <= '0;
      end else if (sample_en) begin
         if (state == IDLE) begin
            if (fss) begin
               state <= SHIFT;
               bitcnt <= '0;
            end
         end else begin
            shreg <= din[DW-2:0];
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BW'(DW-1)) begin
               state <= fss ? SHIFT : IDLE;
               bitcnt <= '0;
            end
         end
      end

   assign pop = rd_en && !rx_empty;
   assign wr = push && (!SSPRXINTR || rd_en);
   assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
   assign cnt_next = rx_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};

   always_ff @(posedge PCLK)
      if (wr) mem[wr_ptr] <= din;

   // head register: a word written straight into the next head slot bypasses the array
   always_ff @(posedge PCLK or negedge CLEAR_B)
      if (!CLEAR_B) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         rx_count <= '0;
         rx_empty <= 1'b1;
         SSPRXINTR <= 1'b0;
         RxData <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_next;
         rx_count <= cnt_next;
         rx_empty <= cnt_next == '0;
         SSPRXINTR <= cnt_next == (AW+1)'(DEPTH);
         if (cnt_next != '0) RxData <= (wr && wr_ptr == rd_next) ? din : mem[rd_next];
      end

`ifdef SSP_RX_OVERRUN_EN
   always_ff @(posedge PCLK or negedge CLEAR_B)
      if (!CLEAR_B) rx_overrun <= 1'b0;
      else if (push && SSPRXINTR && !rd_en) rx_overrun <= 1'b1;
      else if (ovr_clr) rx_overrun <= 1'b0;
`endif
endmodule

// File: tb/tb_ssp_rx.sv
// tb_ssp_rx: table-driven and scoreboard checks of the ssp_rx receiver and its FIFO.
module tb_ssp_rx;
   logic PCLK = 1'b0, CLEAR_B = 1'b0;
   logic SSPCLKIN = 1'b0, SSPFSSIN = 1'b0, SSPRXD = 1'b0, rd_en = 1'b0;
   logic [7:0] RxData;
   logic rx_empty, SSPRXINTR;
   logic [2:0] rx_count;
`ifdef SSP_RX_OVERRUN_EN
   logic rx_overrun, ovr_clr = 1'b0;
`endif
   int total = 0, passed = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] d;
      int half;
      logic [2:0] cnt;
      logic full;
   } vec_t;
   vec_t vt[5];

   ssp_rx #(.DEPTH(4), .DW(8)) dut (
      .PCLK(PCLK), .CLEAR_B(CLEAR_B), .SSPCLKIN(SSPCLKIN), .SSPFSSIN(SSPFSSIN),
      .SSPRXD(SSPRXD), .rd_en(rd_en), .RxData(RxData), .rx_empty(rx_empty),
      .SSPRXINTR(SSPRXINTR),
`ifdef SSP_RX_OVERRUN_EN
      .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
`endif
      .rx_count(rx_count)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic phase(input logic c, input logic f, input logic d, input int half);
      SSPCLKIN = c;
      SSPFSSIN = f;
      SSPRXD = d;
      repeat (half) @(negedge PCLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input int half, input bit lead, input bit tail, input int nb);
      if (lead) begin
         phase(1'b1, 1'b1, 1'b0, half);
         phase(1'b0, 1'b1, 1'b0, half);
      end
      for (int i = 0; i < nb; i++) begin
         phase(1'b1, tail && i == 7, d[7-i], half);
         phase(1'b0, tail && i == 7, d[7-i], half);
      end
   endtask

   task automatic sb_push(input logic [7:0] d);
      if (exp_q.size() < 4) exp_q.push_back(d);
   endtask

   task automatic pop_check();
      logic [7:0] e;
      e = exp_q.pop_front();
      check("pop_not_empty", rx_empty, 1'b0);
      check("pop_data", RxData, e);
      rd_en = 1'b1;
      @(negedge PCLK);
      rd_en = 1'b0;
      @(negedge PCLK);
   endtask

   task automatic settle();
      repeat (5) @(negedge PCLK);
   endtask

   initial begin
      vt[0] = '{8'h11, 1, 3'd1, 1'b0};
      vt[1] = '{8'h22, 2, 3'd2, 1'b0};
      vt[2] = '{8'h33, 1, 3'd3, 1'b0};
      vt[3] = '{8'h44, 3, 3'd4, 1'b1};
      vt[4] = '{8'h55, 1, 3'd4, 1'b1};

      repeat (3) @(negedge PCLK);
      check("reset_empty", rx_empty, 1'b1);
      check("reset_count", rx_count, 3'd0);
      check("reset_full", SSPRXINTR, 1'b0);
      check("reset_data", RxData, 8'h00);
      CLEAR_B = 1'b1;
      repeat (3) @(negedge PCLK);

      // latency: LSB fall at the pin to rx_empty=0 takes exactly 4 PCLK edges
      send_frame(8'hA5, 1, 1, 0, 8);
      sb_push(8'hA5);
      repeat (2) @(negedge PCLK);
      check("lat3_empty", rx_empty, 1'b1);
      @(negedge PCLK);
      check("lat4_empty", rx_empty, 1'b0);
      check("lat4_count", rx_count, 3'd1);
      pop_check();
      check("a5_drained", rx_empty, 1'b1);

      send_frame(8'h3C, 3, 1, 1, 8);
      sb_push(8'h3C);
      send_frame(8'hC3, 3, 0, 0, 8);
      sb_push(8'hC3);
      settle();
      check("b2b_count", rx_count, 3'd2);
      pop_check();
      pop_check();
      check("b2b_drained", rx_empty, 1'b1);

      foreach (vt[i]) begin
         send_frame(vt[i].d, vt[i].half, 1, 0, 8);
         sb_push(vt[i].d);
         settle();
         check("fill_count", rx_count, vt[i].cnt);
         check("fill_full", SSPRXINTR, vt[i].full);
      end
`ifdef SSP_RX_OVERRUN_EN
      check("ovr_set", rx_overrun, 1'b1);
      repeat (3) @(negedge PCLK);
      check("ovr_sticky", rx_overrun, 1'b1);
      ovr_clr = 1'b1;
      @(negedge PCLK);
      ovr_clr = 1'b0;
      check("ovr_cleared", rx_overrun, 1'b0);
`endif
      while (exp_q.size() > 0) pop_check();
      check("fill_drained", rx_count, 3'd0);

      for (int i = 0; i < 4; i++) begin
         send_frame(vt[i].d, 1, 1, 0, 8);
         sb_push(vt[i].d);
         settle();
      end
      check("full_again", SSPRXINTR, 1'b1);
      // rd_en lands in the cycle the 5th word is pushed
      send_frame(8'h55, 1, 1, 0, 8);
      repeat (2) @(negedge PCLK);
      rd_en = 1'b1;
      @(negedge PCLK);
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'h55);
      settle();
      check("simul_count", rx_count, 3'd4);
      check("simul_full", SSPRXINTR, 1'b1);
`ifdef SSP_RX_OVERRUN_EN
      check("simul_no_ovr", rx_overrun, 1'b0);
`endif
      while (exp_q.size() > 0) pop_check();
      check("simul_drained", rx_empty, 1'b1);

      rd_en = 1'b1;
      repeat (5) @(negedge PCLK);
      rd_en = 1'b0;
      check("empty_pop_count", rx_count, 3'd0);
      check("empty_pop_empty", rx_empty, 1'b1);
      SSPFSSIN = 1'b1;
      repeat (3) @(negedge PCLK);
      SSPFSSIN = 1'b0;
      settle();
      check("glitch_count", rx_count, 3'd0);
      send_frame(8'hFF, 1, 0, 0, 8);
      settle();
      check("idle_no_fss_count", rx_count, 3'd0);
      send_frame(8'h5A, 2, 1, 0, 8);
      sb_push(8'h5A);
      settle();
      check("after_glitch_count", rx_count, 3'd1);
      pop_check();

      send_frame(8'h77, 1, 1, 0, 8);
      sb_push(8'h77);
      settle();
      check("pre_reset_count", rx_count, 3'd1);
      send_frame(8'hF0, 1, 1, 0, 3);
      #2;
      CLEAR_B = 1'b0;
      #1;
      check("async_empty", rx_empty, 1'b1);
      check("async_count", rx_count, 3'd0);
      check("async_full", SSPRXINTR, 1'b0);
      check("async_data", RxData, 8'h00);
      exp_q.delete();
      SSPCLKIN = 1'b0;
      SSPFSSIN = 1'b0;
      SSPRXD = 1'b0;
      repeat (2) @(negedge PCLK);
      CLEAR_B = 1'b1;
      repeat (2) @(negedge PCLK);
      send_frame(8'h96, 1, 1, 0, 8);
      sb_push(8'h96);
      settle();
      check("post_reset_count", rx_count, 3'd1);
      pop_check();
      check("post_reset_drained", rx_empty, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
